// File: rtl/hazard3_fetch_aligner.sv
`default_nettype none
// ============================================================================
// hazard3_fetch_aligner : 3-parcel halfword realignment buffer, fetch -> expander.
// Optional macro HAZARD3_FETCH_ALIGN_ERR_EN stores per-parcel bus errors.
// Revision: 1.0
// ============================================================================
module hazard3_fetch_aligner #(
    parameter int EXTENSION_C = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_wdata,
    input  logic        fetch_err,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic        flush,
    input  logic        flush_addr_bit1,
    output logic [31:0] instr_data,
    output logic        instr_is_32bit,
    output logic        instr_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [1:0]  level
);

    localparam logic C_EXT = (EXTENSION_C != 0);

    logic [2:0][15:0] hw_q, hw_d;
    logic [1:0]       level_q, level_d;
    logic             skip_lo_q, skip_lo_d;

    logic             w_is_32bit;
    logic             w_instr_valid;
    logic             w_fetch_ready;
    logic             w_consume;
    logic             w_accept;
    logic [1:0]       w_n_cons;
    logic [1:0]       w_level_sh;
    logic             w_slot;
    logic [2:0][15:0] w_hw_sh;

    assign w_is_32bit    = C_EXT ? (hw_q[0][1:0] == 2'b11) : 1'b1;
    assign w_instr_valid = ((level_q != 2'd0) && !w_is_32bit) || (level_q >= 2'd2);
    assign w_fetch_ready = (level_q <= 2'd1);
    assign w_consume     = w_instr_valid && instr_ready;
    assign w_accept      = fetch_valid && w_fetch_ready && !flush;
    assign w_n_cons      = !w_consume ? 2'd0 : (w_is_32bit ? 2'd2 : 2'd1);
    assign w_level_sh    = level_q - w_n_cons;
    // An accept implies level_q <= 1, so the first free post-shift slot is 0 or 1.
    assign w_slot        = w_level_sh[0];

    always_comb begin
        case (w_n_cons)
            2'd1:    w_hw_sh = {16'h0000, hw_q[2], hw_q[1]};
            2'd2:    w_hw_sh = {16'h0000, 16'h0000, hw_q[2]};
            default: w_hw_sh = hw_q;
        endcase
    end

    always_comb begin
        hw_d      = w_hw_sh;
        level_d   = w_level_sh;
        skip_lo_d = skip_lo_q;
        if (flush) begin
            hw_d      = hw_q;
            level_d   = 2'd0;
            skip_lo_d = flush_addr_bit1 & C_EXT;
        end else if (w_accept) begin
            skip_lo_d = 1'b0;
            if (skip_lo_q) begin
                if (w_slot) hw_d[1] = fetch_wdata[31:16];
                else        hw_d[0] = fetch_wdata[31:16];
                level_d = w_level_sh + 2'd1;
            end else begin
                if (w_slot) begin
                    hw_d[1] = fetch_wdata[15:0];
                    hw_d[2] = fetch_wdata[31:16];
                end else begin
                    hw_d[0] = fetch_wdata[15:0];
                    hw_d[1] = fetch_wdata[31:16];
                end
                level_d = w_level_sh + 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_q      <= '0;
            level_q   <= 2'd0;
            skip_lo_q <= 1'b0;
        end else begin
            hw_q      <= hw_d;
            level_q   <= level_d;
            skip_lo_q <= skip_lo_d;
        end
    end

`ifdef HAZARD3_FETCH_ALIGN_ERR_EN
    logic [2:0] err_q, err_d;
    logic [2:0] w_err_sh;

    always_comb begin
        case (w_n_cons)
            2'd1:    w_err_sh = {1'b0, err_q[2], err_q[1]};
            2'd2:    w_err_sh = {2'b00, err_q[2]};
            default: w_err_sh = err_q;
        endcase
        err_d = w_err_sh;
        if (flush) begin
            err_d = err_q;
        end else if (w_accept) begin
            if (skip_lo_q) begin
                if (w_slot) err_d[1] = fetch_err;
                else        err_d[0] = fetch_err;
            end else begin
                if (w_slot) begin
                    err_d[1] = fetch_err;
                    err_d[2] = fetch_err;
                end else begin
                    err_d[0] = fetch_err;
                    err_d[1] = fetch_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 3'b000;
        end else begin
            err_q <= err_d;
        end
    end

    assign instr_err = err_q[0] | (w_is_32bit & err_q[1]);
`else
    logic unused_fetch_err;
    assign unused_fetch_err = fetch_err;
    assign instr_err        = 1'b0;
`endif

    assign fetch_ready    = w_fetch_ready;
    assign instr_valid    = w_instr_valid;
    assign instr_is_32bit = w_is_32bit;
    assign instr_data     = {hw_q[1], hw_q[0]};
    assign level          = level_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard3_fetch_aligner.sv
`default_nettype none
// ============================================================================
// tb_hazard3_fetch_aligner : scoreboard bench against a parcel-queue reference model.
// Revision: 1.0
// ============================================================================
module tb_hazard3_fetch_aligner;

    localparam int EXT = 1;
`ifdef HAZARD3_FETCH_ALIGN_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_wdata;
    logic        fetch_err;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        flush;
    logic        flush_addr_bit1;
    logic [31:0] instr_data;
    logic        instr_is_32bit;
    logic        instr_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  level;

    hazard3_fetch_aligner #(.EXTENSION_C(EXT)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_wdata     (fetch_wdata),
        .fetch_err       (fetch_err),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .flush           (flush),
        .flush_addr_bit1 (flush_addr_bit1),
        .instr_data      (instr_data),
        .instr_is_32bit  (instr_is_32bit),
        .instr_err       (instr_err),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .level           (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] p;
        logic        e;
    } parc_t;

    typedef struct packed {
        logic        is32;
        logic        err;
        logic [31:0] data;
    } ent_t;

    parc_t mq[$];
    logic  mskip;
    ent_t  got[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic rnd_mode  = 1'b0;
    logic rnd_flush = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic p_is32(input logic [15:0] p);
        return (EXT == 0) || (p[1:0] == 2'b11);
    endfunction

    // Reference model: the buffer is a FIFO of parcels; an instruction is the
    // head parcel (plus the next one if the head is a 32-bit opcode).
    int   m_sz;
    logic m_e32, m_ev, m_acc, m_err;
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mskip = 1'b0;
        end else begin
            m_sz  = mq.size();
            m_e32 = (m_sz >= 1) ? p_is32(mq[0].p) : 1'b0;
            m_ev  = ((m_sz >= 1) && !m_e32) || (m_sz >= 2);
            check("fetch_ready", {31'b0, fetch_ready}, {31'b0, (m_sz <= 1)});
            check("level", {30'b0, level}, m_sz);
            check("instr_valid", {31'b0, instr_valid}, {31'b0, m_ev});
            if (m_ev) begin
                check("instr_is_32bit", {31'b0, instr_is_32bit}, {31'b0, m_e32});
                check("instr_lo", {16'h0, instr_data[15:0]}, {16'h0, mq[0].p});
                m_err = mq[0].e;
                if (m_e32) begin
                    check("instr_hi", {16'h0, instr_data[31:16]}, {16'h0, mq[1].p});
                    m_err = m_err | mq[1].e;
                end
                check("instr_err", {31'b0, instr_err}, {31'b0, m_err & EXP_ERR});
            end
            if (flush) begin
                mq.delete();
                mskip = flush_addr_bit1 && (EXT != 0);
            end else begin
                m_acc = fetch_valid && (m_sz <= 1);
                if (m_ev && instr_ready) begin
                    got.push_back({instr_is_32bit, instr_err,
                                   instr_is_32bit ? instr_data : {16'h0, instr_data[15:0]}});
                    void'(mq.pop_front());
                    if (m_e32) void'(mq.pop_front());
                end
                if (m_acc) begin
                    if (!mskip) mq.push_back({fetch_wdata[15:0], fetch_err});
                    mq.push_back({fetch_wdata[31:16], fetch_err});
                    mskip = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) instr_ready = ($urandom_range(0, 3) != 0);
        flush = rnd_flush ? ($urandom_range(0, 31) == 0) : 1'b0;
        if (rnd_flush) flush_addr_bit1 = $urandom_range(0, 1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic e);
        logic acc;
        fetch_wdata = d;
        fetch_err   = e;
        fetch_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = fetch_ready && !flush;
            tick();
        end
        fetch_valid = 1'b0;
        if (!acc) check("fetch_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic idle;
        instr_ready = 1'b1;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            tick();
            idle = (mq.size() == 0) || (mq.size() == 1 && p_is32(mq[0].p));
        end
        check("drain_timeout", {31'b0, idle}, 32'd1);
    endtask

    task automatic do_flush(input logic b1);
        flush = 1'b1;
        flush_addr_bit1 = b1;
        tick();
    endtask

    task automatic check_got(input int idx, input logic is32, input logic err, input logic [31:0] d);
        if (idx >= got.size()) begin
            check("got_missing", got.size(), idx + 1);
        end else begin
            check("got_data", got[idx].data, d);
            check("got_is32", {31'b0, got[idx].is32}, {31'b0, is32});
            check("got_err", {31'b0, got[idx].err}, {31'b0, err});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        fetch_wdata = 32'h0;
        fetch_err = 1'b0;
        fetch_valid = 1'b0;
        flush = 1'b0;
        flush_addr_bit1 = 1'b0;
        instr_ready = 1'b0;
        repeat (2) tick();
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
        check("rst_instr_err", {31'b0, instr_err}, 32'd0);
        check("rst_instr_data", instr_data, 32'd0);
        check("rst_level", {30'b0, level}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Two compressed instructions from one word
        got.delete();
        instr_ready = 1'b1;
        send_word(32'h4501_0505, 1'b0);
        drain();
        check("t1_count", got.size(), 2);
        check_got(0, 1'b0, 1'b0, 32'h0000_0505);
        check_got(1, 1'b0, 1'b0, 32'h0000_4501);
        check("t1_level", {30'b0, level}, 32'd0);

        // 32-bit instruction straddling two words
        got.delete();
        send_word(32'h0513_4501, 1'b0);
        send_word(32'h4505_0010, 1'b0);
        drain();
        check("t2_count", got.size(), 3);
        check_got(0, 1'b0, 1'b0, 32'h0000_4501);
        check_got(1, 1'b1, 1'b0, 32'h0010_0513);
        check_got(2, 1'b0, 1'b0, 32'h0000_4505);

        // Flush to an odd halfword with competing handshakes in the same cycle
        instr_ready = 1'b0;
        send_word(32'h4501_0505, 1'b0);
        got.delete();
        fetch_wdata = 32'hDEAD_BEEF;
        fetch_valid = 1'b1;
        instr_ready = 1'b1;
        do_flush(1'b1);
        fetch_valid = 1'b0;
        check("t3_valid_after_flush", {31'b0, instr_valid}, 32'd0);
        check("t3_ready_after_flush", {31'b0, fetch_ready}, 32'd1);
        check("t3_level_after_flush", {30'b0, level}, 32'd0);
        send_word(32'h0001_0505, 1'b0);
        drain();
        check("t3_count", got.size(), 1);
        check_got(0, 1'b0, 1'b0, 32'h0000_0001);

        // Backpressure with fetch_valid held
        got.delete();
        instr_ready = 1'b0;
        send_word(32'h4501_0505, 1'b0);
        fetch_wdata = 32'h4509_4509;
        fetch_valid = 1'b1;
        repeat (4) tick();
        check("t4_level_sat", {30'b0, level}, 32'd2);
        check("t4_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        instr_ready = 1'b1;
        send_word(32'h4509_4509, 1'b0);
        drain();
        check("t4_count", got.size(), 4);
        check_got(0, 1'b0, 1'b0, 32'h0000_0505);
        check_got(1, 1'b0, 1'b0, 32'h0000_4501);
        check_got(2, 1'b0, 1'b0, 32'h0000_4509);
        check_got(3, 1'b0, 1'b0, 32'h0000_4509);

        // Fill to level 3, then asynchronous reset between edges
        do_flush(1'b1);
        instr_ready = 1'b0;
        send_word(32'h4501_0505, 1'b0);
        send_word(32'h4503_0507, 1'b0);
        check("t6_level3", {30'b0, level}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_level", {30'b0, level}, 32'd0);
        check("t6_async_valid", {31'b0, instr_valid}, 32'd0);
        check("t6_async_fready", {31'b0, fetch_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Error propagation, including into a straddling instruction
        got.delete();
        instr_ready = 1'b1;
        send_word(32'h0513_4501, 1'b1);
        send_word(32'h4505_0010, 1'b0);
        drain();
        check("t5_count", got.size(), 3);
        check_got(0, 1'b0, EXP_ERR, 32'h0000_4501);
        check_got(1, 1'b1, EXP_ERR, 32'h0010_0513);
        check_got(2, 1'b0, 1'b0, 32'h0000_4505);

        // Randomised traffic with random backpressure and flushes
        rnd_mode  = 1'b1;
        rnd_flush = 1'b1;
        for (int w = 0; w < 300; w++) begin
            send_word($urandom, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd_mode  = 1'b0;
        rnd_flush = 1'b0;
        flush = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard3_fetch_aligner.md
# hazard3_fetch_aligner

Halfword realignment buffer between the instruction fetch bus and the compressed-instruction expander. It accepts naturally aligned 32-bit fetch words and holds up to three 16-bit parcels. It presents one complete instruction per handshake, 16-bit or 32-bit, at parcel offset 0, and tracks word-straddling 32-bit instructions and mid-word jump targets. Its output feeds the decompressor input directly; its `instr_is_32bit` output uses the same `[1:0] == 2'b11` rule as the decompressor.

## Interface
- `EXTENSION_C`, default 1: when 0, every instruction is 32-bit and `flush_addr_bit1` is ignored.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset. One clock; reset is asynchronous and active-low.
- `fetch_wdata  in  32`: fetched word; parcel 0 = [15:0], parcel 1 = [31:16].
- `fetch_err  in  1`: bus error for this word.
- `fetch_valid  in  1`: word available.
- `fetch_ready  out  1`: buffer can take a word.
- `flush  in  1`: discard buffer contents (jump/trap).
- `flush_addr_bit1  in  1`: bit 1 of the new PC, sampled with `flush`.
- `instr_data  out  32`: {parcel1, parcel0}; the upper half is don't-care for 16-bit instructions.
- `instr_is_32bit  out  1`: `instr_data[1:0] == 2'b11` (forced 1 if `EXTENSION_C` = 0).
- `instr_err  out  1`: error flag of any parcel belonging to the presented instruction.
- `instr_valid  out  1`: complete instruction present.
- `instr_ready  in  1`: consumer takes the instruction.
- `level  out  2`: parcels held, 0..3 (debug/perf).

## Operation
- State: parcels `hw[0..2]` (16 b each), per-parcel error bits, `level` (0..3), and `skip_lo` (1 b).
- Fetch handshake:
  - `fetch_ready = (level <= 1)`, decoded from registers only.
  - A word is accepted when `fetch_valid && fetch_ready && !flush`.
  - If `skip_lo` = 1, only parcel 1 is appended (+1) and `skip_lo` clears. Otherwise both parcels are appended in order (+2).
- Instruction valid:
  - `instr_valid = (level >= 1 && !instr_is_32bit) || (level >= 2)`.
  - `instr_data = {hw1, hw0}`, taken straight from registers with no bypass from `fetch_wdata`.
- Consume: on `instr_valid && instr_ready`, the buffer shifts down by 1 parcel (16-bit) or 2 parcels (32-bit).
- Simultaneous consume and accept:
  - The shift happens first; new parcels are written at post-shift positions.
  - Next level = `level − consumed + appended`. It never exceeds 3 and never underflows.
- Flush has priority over everything else:
  - Sets `level` to 0 and `skip_lo` to `flush_addr_bit1 & EXTENSION_C`.
  - Any word or instruction handshake in the same cycle has no effect on state.
  - The consumer owns flush ordering.
- `instr_err`:
  - 16-bit instruction: err(hw0).
  - 32-bit instruction: err(hw0) | err(hw1).
- `EXTENSION_C` = 0: `skip_lo` is tied 0 and consumption is always 2 parcels.
- Reset values: `level` = 0, `skip_lo` = 0, parcels and error bits = 0. Therefore `instr_valid` = 0, `fetch_ready` = 1, `instr_err` = 0, and `instr_data` = 0.
- Reset asserted mid-operation clears all state immediately (asynchronous). There is no partial instruction retention.

## Timing
- Word accepted in cycle N gives earliest `instr_valid` in cycle N+1.
- Throughput: one instruction per cycle while fed; one word per cycle while `level <= 1`.
- A 32-bit instruction straddling a word boundary is valid in the cycle after the second word is accepted.
- Flush in cycle N:
  - `instr_valid` = 0 in N+1.
  - `fetch_ready` = 1 in N+1.
  - First instruction of the new stream no earlier than N+2.
- `fetch_ready` and `instr_valid` do not depend combinationally on `instr_ready` or `fetch_valid`.

## Configuration
- `HAZARD3_FETCH_ALIGN_ERR_EN` defined: per-parcel error bits are stored and `instr_err` is as specified above.
- Not defined:
  - No error storage.
  - `fetch_err` is ignored.
  - `instr_err` is tied 0.
  - All other behaviour is identical.

## Test plan
- Reset, then one word 0x4501_0505 with `instr_ready` = 1 → 0x0505 (16-bit), then 0x4501 (16-bit); `level` returns to 0.
- Straddle: words 0x0513_4501, then 0x4505_0010 → outputs 0x4501 (16-bit), 0x0010_0513 (32-bit), 0x4505 (16-bit).
- Flush with `flush_addr_bit1` = 1, then word 0x0001_0505 → only 0x0001 is presented. A word or consume handshake in the flush cycle has no effect, and `instr_valid` = 0 the cycle after flush.
- Backpressure: `instr_ready` = 0 with `fetch_valid` held → `level` saturates at 2 or 3, `fetch_ready` = 0, no parcel lost. Release → stream completes in order.
- Error (macro defined): word 0x0513_4501 with `fetch_err` = 1, next word clean → 0x4501 has `instr_err` = 1, and the straddling 32-bit instruction also has `instr_err` = 1. With the macro undefined, both have `instr_err` = 0.
- `rst_n` low mid-stream with `level` = 3 → `level` = 0 and `instr_valid` = 0 immediately, without waiting for a clock edge.
